// File: rtl/mix_pkg.sv
// Shared types and default widths for the time-multiplexed mixer scheduler.
package mix_pkg;

    localparam int DW_DEF       = 16;
    localparam int MULT_LAT_DEF = 2;
    localparam int OUT_MSB_DEF  = 27;
    localparam int OUT_LSB_DEF  = 12;

    typedef enum logic [1:0] {SLOT_1I, SLOT_1Q, SLOT_2I, SLOT_2Q} slot_e;

    typedef enum logic {IDLE, ISSUE} state_e;

    // Travels alongside each product so the output stage knows where it belongs.
    typedef struct packed {
        logic  vld;
        slot_e slot;
    } tag_t;

endpackage

// File: rtl/mix_mult_pipe.sv
// Shared signed DW x DW multiplier with LAT register stages and async clear.
module mix_mult_pipe #(
    parameter int DW  = 16,
    parameter int LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [DW-1:0]   a,
    input  logic signed [DW-1:0]   b,
    output logic signed [2*DW-1:0] p
);

    localparam int PW = 2 * DW;

    logic signed [PW-1:0] stage [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= PW'(a) * PW'(b);
            for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign p = stage[LAT-1];

endmodule

// File: rtl/mix_sched.sv
// Mixer scheduler: issues the four products of one ADC/NCO sample through one
// shared multiplier, rounds them and presents all four results together.
module mix_sched
    import mix_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int OUT_MSB  = OUT_MSB_DEF,
    parameter int OUT_LSB  = OUT_LSB_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VLD,
    output logic          IN_RDY,
    input  logic [DW-1:0] ADCDATA,
    input  logic [DW-1:0] ADCDATB,
    input  logic [DW-1:0] NCO_I,
    input  logic [DW-1:0] NCO_Q,
    output logic [DW-1:0] MIX1_DATI,
    output logic [DW-1:0] MIX1_DATQ,
    output logic [DW-1:0] MIX2_DATI,
    output logic [DW-1:0] MIX2_DATQ,
    output logic          OUT_VLD,
    output logic          OVERRUN,
    input  logic          CLR_OVR
);

    state_e               state, state_nxt;
    slot_e                slot, slot_nxt;
    logic                 run;
    logic                 xfer;
    logic [DW-1:0]        hold_a, hold_b, hold_i, hold_q;
    logic signed [DW-1:0] mul_a, mul_b;
    logic signed [2*DW-1:0] prod;
    tag_t                 tag [MULT_LAT];
    tag_t                 tag_out;
    logic [DW-1:0]        rnd;
    logic [DW-1:0]        stg [3];
    logic                 unused_prod_bits;

    // run holds IN_RDY low until the first edge after reset release.
    assign IN_RDY = run & ((state == IDLE) || (state == ISSUE && slot == SLOT_2Q));
    assign xfer   = IN_VLD & IN_RDY;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        slot_nxt  = slot;
        case (state)
            IDLE: begin
                if (xfer) begin
                    state_nxt = ISSUE;
                    slot_nxt  = SLOT_1I;
                end
            end
            ISSUE: begin
                if (slot == SLOT_2Q) begin
                    slot_nxt  = SLOT_1I;
                    state_nxt = xfer ? ISSUE : IDLE;
                end else begin
                    slot_nxt = slot_e'(slot + 2'd1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            slot  <= SLOT_1I;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            slot  <= slot_nxt;
            run   <= 1'b1;
        end
    end

    // NOTE: operand holding registers are pure datapath, qualified by the FSM, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (xfer) begin
            hold_a <= ADCDATA;
            hold_b <= ADCDATB;
            hold_i <= NCO_I;
            hold_q <= NCO_Q;
        end
    end

    // Slot bit 1 selects the ADC channel, bit 0 selects cosine/sine.
    assign mul_a = slot[1] ? hold_b : hold_a;
    assign mul_b = slot[0] ? hold_q : hold_i;

    mix_mult_pipe #(
        .DW  (DW),
        .LAT (MULT_LAT)
    ) u_mult (
        .clk   (CLK),
        .rst_n (RST_N),
        .a     (mul_a),
        .b     (mul_b),
        .p     (prod)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < MULT_LAT; i++) tag[i] <= '{vld: 1'b0, slot: SLOT_1I};
        end else begin
            tag[0] <= '{vld: (state == ISSUE), slot: slot};
            for (int i = 1; i < MULT_LAT; i++) tag[i] <= tag[i-1];
        end
    end

    assign tag_out = tag[MULT_LAT-1];

    // Round half up on the kept field; overflow wraps.
    assign rnd = DW'(prod[OUT_MSB:OUT_LSB]) + DW'(prod[OUT_LSB-1]);
    assign unused_prod_bits = ^{prod[2*DW-1:OUT_MSB+1], prod[OUT_LSB-2:0]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the staging array is explicitly cleared because reset must discard partial results.
            for (int i = 0; i < 3; i++) stg[i] <= '0;
            MIX1_DATI <= '0;
            MIX1_DATQ <= '0;
            MIX2_DATI <= '0;
            MIX2_DATQ <= '0;
            OUT_VLD   <= 1'b0;
        end else begin
            OUT_VLD <= 1'b0;
            if (tag_out.vld) begin
                if (tag_out.slot == SLOT_2Q) begin
                    MIX1_DATI <= stg[0];
                    MIX1_DATQ <= stg[1];
                    MIX2_DATI <= stg[2];
                    MIX2_DATQ <= rnd;
                    OUT_VLD   <= 1'b1;
                end else begin
                    stg[tag_out.slot] <= rnd;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OVERRUN <= 1'b0;
        end else begin
            OVERRUN <= (IN_VLD & ~IN_RDY) | (OVERRUN & ~CLR_OVR);
        end
    end

endmodule

// File: tb/tb_mix_sched.sv
// Self-checking bench for mix_sched: vector table, randomized scoreboard run,
// and hand-written overrun / mid-operation reset sequences.
module tb_mix_sched;

    typedef struct {
        logic [15:0] a, b, i, q;
        logic [63:0] exp;   // {1I, 1Q, 2I, 2Q}
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        IN_VLD = 1'b0;
    logic        CLR_OVR = 1'b0;
    logic [15:0] ADCDATA = '0, ADCDATB = '0, NCO_I = '0, NCO_Q = '0;

    logic        in_rdy, out_vld, overrun;
    logic [15:0] mix1_i, mix1_q, mix2_i, mix2_q;
    logic        in_rdy4, out_vld4, overrun4;
    logic [15:0] mix1_i4, mix1_q4, mix2_i4, mix2_q4;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] exp_q [$];

    always #5 CLK = ~CLK;

    mix_sched #(.MULT_LAT(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VLD(IN_VLD), .IN_RDY(in_rdy),
        .ADCDATA(ADCDATA), .ADCDATB(ADCDATB), .NCO_I(NCO_I), .NCO_Q(NCO_Q),
        .MIX1_DATI(mix1_i), .MIX1_DATQ(mix1_q), .MIX2_DATI(mix2_i), .MIX2_DATQ(mix2_q),
        .OUT_VLD(out_vld), .OVERRUN(overrun), .CLR_OVR(CLR_OVR)
    );

    mix_sched #(.MULT_LAT(4)) dut4 (
        .CLK(CLK), .RST_N(RST_N), .IN_VLD(IN_VLD), .IN_RDY(in_rdy4),
        .ADCDATA(ADCDATA), .ADCDATB(ADCDATB), .NCO_I(NCO_I), .NCO_Q(NCO_Q),
        .MIX1_DATI(mix1_i4), .MIX1_DATQ(mix1_q4), .MIX2_DATI(mix2_i4), .MIX2_DATQ(mix2_q4),
        .OUT_VLD(out_vld4), .OVERRUN(overrun4), .CLR_OVR(CLR_OVR)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: full-precision product, keep bits 27:12, add bit 11, wrap to 16 bits.
    function automatic logic [15:0] ref_prod(input logic [15:0] x, input logic [15:0] y);
        int xs, ys, p, r;
        xs = int'($signed(x));
        ys = int'($signed(y));
        p  = xs * ys;
        r  = (p >>> 12) + ((p >>> 11) & 1);
        return r[15:0];
    endfunction

    function automatic logic [63:0] ref_mix(input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] i, input logic [15:0] q);
        return {ref_prod(a, i), ref_prod(a, q), ref_prod(b, i), ref_prod(b, q)};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_rdy();
        for (int k = 0; k < 50 && !in_rdy; k++) step();
        check("rdy_wait", in_rdy, 1'b1);
    endtask

    task automatic drive(input vec_t v);
        ADCDATA = v.a;
        ADCDATB = v.b;
        NCO_I   = v.i;
        NCO_Q   = v.q;
    endtask

    task automatic scramble();
        ADCDATA = 16'($urandom);
        ADCDATB = 16'($urandom);
        NCO_I   = 16'($urandom);
        NCO_Q   = 16'($urandom);
    endtask

    // One isolated sample; checks latency in both builds and the four results.
    task automatic send_single(input vec_t v, input string tag);
        int lat, lat4, pulses, pulses4;
        logic [63:0] got, got4;
        lat = -1; lat4 = -1; pulses = 0; pulses4 = 0; got = '0; got4 = '0;
        wait_rdy();
        IN_VLD = 1'b1;
        drive(v);
        step();
        IN_VLD = 1'b0;
        scramble();
        check({tag, "_rdy_busy"}, in_rdy, 1'b0);
        for (int n = 1; n <= 16; n++) begin
            step();
            if (out_vld) begin
                pulses++;
                if (lat < 0) lat = n;
                got = {mix1_i, mix1_q, mix2_i, mix2_q};
            end
            if (out_vld4) begin
                pulses4++;
                if (lat4 < 0) lat4 = n;
                got4 = {mix1_i4, mix1_q4, mix2_i4, mix2_q4};
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'd6);
        check({tag, "_lat4"}, 64'(lat4), 64'd8);
        check({tag, "_pulses"}, 64'(pulses), 64'd1);
        check({tag, "_pulses4"}, 64'(pulses4), 64'd1);
        check({tag, "_mix"}, got, v.exp);
        check({tag, "_mix4"}, got4, v.exp);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [4];
        vec_t v;
        int k, accepts, outs, last_out, cyc, pulses;
        logic exp_ovr, exp_rdy, vld, accepted;
        logic [63:0] e, got;

        tbl[0] = '{a: 16'h0100, b: 16'h0001, i: 16'h0800, q: 16'h0180, exp: 64'h0080_0018_0001_0000};
        tbl[1] = '{a: 16'hFF00, b: 16'h0000, i: 16'h0100, q: 16'h0000, exp: 64'hFFF0_0000_0000_0000};
        tbl[2] = '{a: 16'h8000, b: 16'h7FFF, i: 16'h8000, q: 16'h7FFF, exp: 64'h0000_0008_0008_FFF0};
        tbl[3] = '{a: 16'hFFFF, b: 16'h0000, i: 16'h0800, q: 16'hF800, exp: 64'h0000_0001_0000_0000};

        // Reset state
        repeat (3) step();
        check("rst_rdy", in_rdy, 1'b0);
        check("rst_vld", out_vld, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_mix", {mix1_i, mix1_q, mix2_i, mix2_q}, 64'h0);
        RST_N = 1'b1;
        step();
        check("rst_rdy_after", in_rdy, 1'b1);

        // Table vectors
        for (int t = 0; t < 4; t++) send_single(tbl[t], $sformatf("vec%0d", t));

        // Back-to-back (first 8) then random-valid traffic against the model
        k = 10; accepts = 0; outs = 0; last_out = -100; cyc = 0; exp_ovr = 1'b0;
        v = '{a: 16'($urandom), b: 16'($urandom), i: 16'($urandom), q: 16'($urandom), exp: '0};
        while ((accepts < 48 || exp_q.size() > 0) && cyc < 3000) begin
            exp_rdy = (k >= 3);
            check("rnd_rdy", in_rdy, exp_rdy);
            check("rnd_ovr", overrun, exp_ovr);
            if (out_vld) begin
                if (exp_q.size() == 0) begin
                    check("rnd_spurious_vld", out_vld, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_mix", {mix1_i, mix1_q, mix2_i, mix2_q}, e);
                    if (outs >= 1 && outs < 8) check("b2b_gap", 64'(cyc - last_out), 64'd4);
                    last_out = cyc;
                    outs++;
                end
            end
            if (accepts < 8)       vld = 1'b1;
            else if (accepts < 48) vld = 1'($urandom_range(0, 1));
            else                   vld = 1'b0;
            IN_VLD = vld;
            drive(v);
            accepted = vld && exp_rdy;
            if (vld && !exp_rdy) exp_ovr = 1'b1;
            if (accepted) begin
                exp_q.push_back(ref_mix(v.a, v.b, v.i, v.q));
                accepts++;
            end
            step();
            cyc++;
            if (accepted) begin
                k = 0;
                v = '{a: 16'($urandom), b: 16'($urandom), i: 16'($urandom), q: 16'($urandom), exp: '0};
            end else begin
                k++;
            end
        end
        IN_VLD = 1'b0;
        check("rnd_drain", 64'(exp_q.size()), 64'd0);
        check("rnd_outs", 64'(outs), 64'd48);
        repeat (12) step();

        // Overrun: offer in slot 0, dropped; then clear
        CLR_OVR = 1'b1;
        step();
        CLR_OVR = 1'b0;
        check("ovr_cleared_pre", overrun, 1'b0);
        wait_rdy();
        IN_VLD = 1'b1;
        drive(tbl[0]);
        step();
        drive(tbl[1]);
        check("ovr_rdy_low", in_rdy, 1'b0);
        step();
        IN_VLD = 1'b0;
        check("ovr_set", overrun, 1'b1);
        pulses = 0; got = '0;
        for (int n = 0; n < 16; n++) begin
            if (out_vld) begin pulses++; got = {mix1_i, mix1_q, mix2_i, mix2_q}; end
            step();
        end
        check("ovr_pulses", 64'(pulses), 64'd1);
        check("ovr_mix", got, tbl[0].exp);
        CLR_OVR = 1'b1;
        step();
        CLR_OVR = 1'b0;
        check("ovr_clear", overrun, 1'b0);

        // Set and clear in the same cycle: set wins
        wait_rdy();
        IN_VLD = 1'b1;
        drive(tbl[1]);
        step();
        CLR_OVR = 1'b1;
        drive(tbl[2]);
        step();
        IN_VLD = 1'b0;
        CLR_OVR = 1'b0;
        check("ovr_set_wins", overrun, 1'b1);
        pulses = 0; got = '0;
        for (int n = 0; n < 16; n++) begin
            if (out_vld) begin pulses++; got = {mix1_i, mix1_q, mix2_i, mix2_q}; end
            step();
        end
        check("ovr2_pulses", 64'(pulses), 64'd1);
        check("ovr2_mix", got, tbl[1].exp);

        // Reset two cycles after acceptance
        wait_rdy();
        IN_VLD = 1'b1;
        drive(tbl[2]);
        step();
        IN_VLD = 1'b0;
        step();
        step();
        RST_N = 1'b0;
        #1;
        check("mrst_mix", {mix1_i, mix1_q, mix2_i, mix2_q}, 64'h0);
        check("mrst_vld", out_vld, 1'b0);
        check("mrst_rdy", in_rdy, 1'b0);
        check("mrst_ovr", overrun, 1'b0);
        step();
        step();
        RST_N = 1'b1;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            step();
            if (out_vld || out_vld4) pulses++;
        end
        check("mrst_no_vld", 64'(pulses), 64'd0);
        check("mrst_mix_hold", {mix1_i, mix1_q, mix2_i, mix2_q}, 64'h0);
        send_single(tbl[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
